// File: rtl/v_query_rsp_buf.sv
// v_query_rsp_buf: accepts client queries, issues them to a one-cycle query
// pipe and buffers the pipe results in a small response FIFO. A reservation
// counter gates new requests so that every issued query already owns a FIFO
// slot, which keeps a compliant pipe from ever overflowing the buffer.

package v_pkg;
    typedef logic [15:0] id_t;
    typedef logic [3:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] volume_t;
    typedef logic [7:0]  listsize_t;

    typedef struct packed {
        key_t      key;
        volume_t   size;
        logic      error;
        listsize_t listsize;
    } rsp_t;
endpackage

module v_query_rsp_buf #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_vld,
    input  v_pkg::id_t         i_req_prod_id,
    input  v_pkg::level_t      i_req_level,
    output logic               o_req_rdy,
    output logic               o_lut_vld,
    output v_pkg::id_t         o_lut_prod_id,
    output v_pkg::level_t      o_lut_level,
    input  logic               i_lut_vld_r,
    input  v_pkg::key_t        i_lut_key,
    input  v_pkg::volume_t     i_lut_size,
    input  logic               i_lut_error,
    input  v_pkg::listsize_t   i_lut_listsize,
    output logic               o_rsp_vld,
    output v_pkg::key_t        o_rsp_key,
    output v_pkg::volume_t     o_rsp_size,
    output logic               o_rsp_error,
    output v_pkg::listsize_t   o_rsp_listsize,
    input  logic               i_rsp_rdy,
    output logic [$clog2(DEPTH):0] o_occ,
    output logic               o_overflow_r
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [OW-1:0] resv_q, resv_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          ign_q, ign_d;

    v_pkg::rsp_t   mem_q [DEPTH];
    v_pkg::rsp_t   wr_entry;
    v_pkg::rsp_t   head;

    logic accept;
    logic pop;
    logic push;
    logic full;
    logic push_ok;

    // Request handshake, zero-cycle issue to the pipe and FIFO event decode
    always_comb begin
        o_req_rdy     = (resv_q != DEPTH_C);
        accept        = i_req_vld & o_req_rdy & rst;
        o_lut_vld     = accept;
        o_lut_prod_id = i_req_prod_id;
        o_lut_level   = i_req_level;
        o_rsp_vld     = (occ_q != '0);
        pop           = o_rsp_vld & i_rsp_rdy;
        push          = i_lut_vld_r & ~ign_q;
        full          = (occ_q == DEPTH_C);
        push_ok       = push & (~full | pop);
    end

    // Error results carry no meaningful key/size, so they are zeroed on entry
    always_comb begin
        wr_entry.key      = i_lut_error ? '0 : i_lut_key;
        wr_entry.size     = i_lut_error ? '0 : i_lut_size;
        wr_entry.error    = i_lut_error;
        wr_entry.listsize = i_lut_listsize;
    end

    // Next-state for reservations, occupancy, pointers and status flags
    always_comb begin
        resv_d   = resv_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        ign_d    = 1'b0;

        if (accept && !pop) begin
            resv_d = resv_q + OW'(1);
        end else if (pop && !accept) begin
            resv_d = resv_q - OW'(1);
        end

        if (push_ok && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push_ok) begin
            occ_d = occ_q - OW'(1);
        end

        // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end

        // A result arriving right after reset belongs to a pre-reset query
        if (!rst) begin
            resv_d   = '0;
            occ_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            ign_d    = 1'b1;
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        resv_q   <= resv_d;
        occ_q    <= occ_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        ovf_q    <= ovf_d;
        ign_q    <= ign_d;
    end

    // Response storage is written in place and deliberately left unreset
    always_ff @(posedge clk) begin
        if (push_ok && rst) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Head-of-queue response and status outputs
    always_comb begin
        head           = mem_q[rd_ptr_q];
        o_rsp_key      = head.key;
        o_rsp_size     = head.size;
        o_rsp_error    = head.error;
        o_rsp_listsize = head.listsize;
        o_occ          = occ_q;
        o_overflow_r   = ovf_q;
    end

endmodule

// File: tb/tb_v_query_rsp_buf.sv
// Testbench for v_query_rsp_buf: acts as the client and as a compliant
// one-cycle query pipe, and compares the DUT against a queue-based model.

module tb_v_query_rsp_buf;
    import v_pkg::*;

    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_vld;
    id_t           i_req_prod_id;
    level_t        i_req_level;
    logic          o_req_rdy;
    logic          o_lut_vld;
    id_t           o_lut_prod_id;
    level_t        o_lut_level;
    logic          i_lut_vld_r;
    key_t          i_lut_key;
    volume_t       i_lut_size;
    logic          i_lut_error;
    listsize_t     i_lut_listsize;
    logic          o_rsp_vld;
    key_t          o_rsp_key;
    volume_t       o_rsp_size;
    logic          o_rsp_error;
    listsize_t     o_rsp_listsize;
    logic          i_rsp_rdy;
    logic [OW-1:0] o_occ;
    logic          o_overflow_r;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the ordered list of buffered responses, the number
    // of queries accepted and not yet handed back, and the status flags
    rsp_t exp_q[$];
    int   resv_m = 0;
    bit   ovf_m  = 1'b0;
    bit   ign_m  = 1'b1;

    always #5 clk = ~clk;

    v_query_rsp_buf #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_vld      (i_req_vld),
        .i_req_prod_id  (i_req_prod_id),
        .i_req_level    (i_req_level),
        .o_req_rdy      (o_req_rdy),
        .o_lut_vld      (o_lut_vld),
        .o_lut_prod_id  (o_lut_prod_id),
        .o_lut_level    (o_lut_level),
        .i_lut_vld_r    (i_lut_vld_r),
        .i_lut_key      (i_lut_key),
        .i_lut_size     (i_lut_size),
        .i_lut_error    (i_lut_error),
        .i_lut_listsize (i_lut_listsize),
        .o_rsp_vld      (o_rsp_vld),
        .o_rsp_key      (o_rsp_key),
        .o_rsp_size     (o_rsp_size),
        .o_rsp_error    (o_rsp_error),
        .o_rsp_listsize (o_rsp_listsize),
        .i_rsp_rdy      (i_rsp_rdy),
        .o_occ          (o_occ),
        .o_overflow_r   (o_overflow_r)
    );

    function automatic bit model_acc();
        return rst && i_req_vld && (resv_m != DEPTH);
    endfunction

    // One clock cycle: apply the spec rules to the model, then play the pipe
    // by returning a random result one cycle after every accepted query
    task automatic tick();
        bit   acc, pop, push;
        rsp_t ent;
        acc  = model_acc();
        pop  = rst && (exp_q.size() != 0) && i_rsp_rdy;
        push = rst && i_lut_vld_r && !ign_m;
        ent.key      = i_lut_error ? '0 : i_lut_key;
        ent.size     = i_lut_error ? '0 : i_lut_size;
        ent.error    = i_lut_error;
        ent.listsize = i_lut_listsize;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            resv_m = 0;
            ovf_m  = 1'b0;
            ign_m  = 1'b1;
        end else begin
            ign_m = 1'b0;
            if (pop) exp_q.delete(0);
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(ent);
                else ovf_m = 1'b1;
            end
            if (acc && !pop) resv_m++;
            else if (pop && !acc) resv_m--;
        end
        #1;
        i_lut_vld_r    = acc;
        i_lut_key      = key_t'($urandom);
        i_lut_size     = volume_t'($urandom);
        i_lut_error    = ($urandom_range(3) == 0);
        i_lut_listsize = listsize_t'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (o_lut_vld !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL reset_lut_vld: got %b expected 0", o_lut_vld);
            end
            tick();
        end
        rst = 1'b1;
        i_req_vld = 1'b0;
        #1;
        n_vec++;
        if ({o_req_rdy, o_rsp_vld, o_occ, o_overflow_r} !== {1'b1, 1'b0, OW'(0), 1'b0}) begin
            n_err++;
            $display("[TB] FAIL reset_state: rdy/vld/occ/ovf got %b/%b/%0d/%b expected 1/0/0/0",
                     o_req_rdy, o_rsp_vld, o_occ, o_overflow_r);
        end
    endtask

    // Query at cycle 0, pipe result at cycle 1, response visible at cycle 2
    task automatic test_single(input bit err, input key_t k, input volume_t s, input listsize_t ls);
        rsp_t want;
        i_req_vld = 1'b1;
        i_req_prod_id = 16'h1234;
        i_req_level = 4'h5;
        #1;
        n_vec++;
        if ({o_lut_vld, o_lut_prod_id, o_lut_level} !== {1'b1, 16'h1234, 4'h5}) begin
            n_err++;
            $display("[TB] FAIL single_issue: vld/id/lvl got %b/%h/%h expected 1/1234/5",
                     o_lut_vld, o_lut_prod_id, o_lut_level);
        end
        tick();
        i_req_vld = 1'b0;
        i_lut_key = k;
        i_lut_size = s;
        i_lut_error = err;
        i_lut_listsize = ls;
        #1;
        n_vec++;
        if (o_rsp_vld !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_no_bypass: rsp_vld got %b expected 0", o_rsp_vld);
        end
        tick();
        want = '{key: err ? key_t'(0) : k, size: err ? volume_t'(0) : s, error: err, listsize: ls};
        #1;
        n_vec++;
        if ({o_rsp_vld, o_occ} !== {1'b1, OW'(1)}) begin
            n_err++;
            $display("[TB] FAIL single_visible: vld/occ got %b/%0d expected 1/1", o_rsp_vld, o_occ);
        end
        n_vec++;
        if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize} !== want) begin
            n_err++;
            $display("[TB] FAIL single_data: got %h expected %h",
                     {o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize}, want);
        end
        i_rsp_rdy = 1'b1;
        tick();
        i_rsp_rdy = 1'b0;
        #1;
        n_vec++;
        if ({o_rsp_vld, o_occ, o_req_rdy} !== {1'b0, OW'(0), 1'b1}) begin
            n_err++;
            $display("[TB] FAIL single_popped: vld/occ/rdy got %b/%0d/%b expected 0/0/1",
                     o_rsp_vld, o_occ, o_req_rdy);
        end
    endtask

    // Six back-to-back requests with the client stalled: only DEPTH fit
    task automatic test_backpressure();
        int accepted = 0;
        i_rsp_rdy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_req_vld = 1'b1;
            i_req_prod_id = id_t'($urandom);
            #1;
            n_vec++;
            if (o_req_rdy !== (k < DEPTH)) begin
                n_err++;
                $display("[TB] FAIL bp_rdy_c%0d: got %b expected %b", k, o_req_rdy, (k < DEPTH));
            end
            if (o_lut_vld === 1'b1) accepted++;
            tick();
        end
        i_req_vld = 1'b0;
        tick();
        n_vec++;
        if (accepted != DEPTH) begin
            n_err++;
            $display("[TB] FAIL bp_accepted: got %0d expected %0d", accepted, DEPTH);
        end
        n_vec++;
        if ({o_occ, o_overflow_r, o_req_rdy} !== {OW'(DEPTH), 1'b0, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL bp_full: occ/ovf/rdy got %0d/%b/%b expected %0d/0/0",
                     o_occ, o_overflow_r, o_req_rdy, DEPTH);
        end
    endtask

    // From a full buffer, pop and request every cycle; one query is always in
    // the pipe, so occupancy settles at DEPTH-2 with one push and one pop
    task automatic test_simultaneous();
        i_rsp_rdy = 1'b1;
        i_req_vld = 1'b1;
        #1;
        n_vec++;
        if (o_req_rdy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL sim_rdy_first_pop: got %b expected 0", o_req_rdy);
        end
        tick();
        #1;
        n_vec++;
        if (o_req_rdy !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL sim_rdy_after_pop: got %b expected 1", o_req_rdy);
        end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if ({o_rsp_vld, o_occ} !== {1'b1, OW'(exp_q.size())}) begin
                n_err++;
                $display("[TB] FAIL sim_occ_c%0d: vld/occ got %b/%0d expected 1/%0d",
                         k, o_rsp_vld, o_occ, exp_q.size());
            end
            n_vec++;
            if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize} !== exp_q[0]) begin
                n_err++;
                $display("[TB] FAIL sim_head_c%0d: got %h expected %h", k,
                         {o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize}, exp_q[0]);
            end
            tick();
            #1;
        end
        n_vec++;
        if (o_occ !== OW'(DEPTH - 2)) begin
            n_err++;
            $display("[TB] FAIL sim_steady_occ: got %0d expected %0d", o_occ, DEPTH - 2);
        end
        i_req_vld = 1'b0;
        for (int k = 0; k < 20 && (exp_q.size() != 0 || resv_m != 0); k++) tick();
        #1;
        n_vec++;
        if ({o_occ, o_rsp_vld, o_req_rdy} !== {OW'(0), 1'b0, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL sim_drain: occ/vld/rdy got %0d/%b/%b expected 0/0/1",
                     o_occ, o_rsp_vld, o_req_rdy);
        end
        i_rsp_rdy = 1'b0;
    endtask

    // Ten queries streamed through, then a pipe push forced into a full FIFO
    task automatic test_wrap_overflow();
        int issued = 0;
        int popped = 0;
        for (int k = 0; k < 60 && popped < 10; k++) begin
            i_req_vld = (issued < 10);
            i_rsp_rdy = 1'($urandom_range(1));
            #1;
            if (model_acc()) issued++;
            if (exp_q.size() != 0 && i_rsp_rdy) begin
                n_vec++;
                if ({o_rsp_vld, o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize} !== {1'b1, exp_q[0]}) begin
                    n_err++;
                    $display("[TB] FAIL wrap_pop%0d: got %h expected %h", popped,
                             {o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize}, exp_q[0]);
                end
                popped++;
            end
            tick();
        end
        n_vec++;
        if (popped != 10) begin
            n_err++;
            $display("[TB] FAIL wrap_count: got %0d responses expected 10", popped);
        end
        i_rsp_rdy = 1'b0;
        i_req_vld = 1'b1;
        for (int k = 0; k < DEPTH; k++) tick();
        i_req_vld = 1'b0;
        tick();
        i_lut_vld_r = 1'b1;
        tick();
        #1;
        n_vec++;
        if ({o_overflow_r, o_occ} !== {1'b1, OW'(DEPTH)}) begin
            n_err++;
            $display("[TB] FAIL ovf_set: ovf/occ got %b/%0d expected 1/%0d", o_overflow_r, o_occ, DEPTH);
        end
        n_vec++;
        if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize} !== exp_q[0]) begin
            n_err++;
            $display("[TB] FAIL ovf_head: got %h expected %h",
                     {o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize}, exp_q[0]);
        end
        i_rsp_rdy = 1'b1;
        tick();
        tick();
        #1;
        n_vec++;
        if (o_overflow_r !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL ovf_sticky: got %b expected 1", o_overflow_r);
        end
        i_rsp_rdy = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Reset with three buffered and one in-flight response, then a stray
    // pipe result right after release
    task automatic test_reset_mid();
        i_rsp_rdy = 1'b0;
        i_req_vld = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        i_req_vld = 1'b0;
        tick();
        i_req_vld = 1'b1;
        #1;
        n_vec++;
        if (o_occ !== OW'(3)) begin
            n_err++;
            $display("[TB] FAIL mid_pre_occ: got %0d expected 3", o_occ);
        end
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (o_lut_vld !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL mid_lut_in_reset: got %b expected 0", o_lut_vld);
        end
        tick();
        rst = 1'b1;
        i_req_vld = 1'b0;
        i_lut_vld_r = 1'b1;
        #1;
        n_vec++;
        if ({o_occ, o_rsp_vld, o_req_rdy, o_overflow_r} !== {OW'(0), 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL mid_after_reset: occ/vld/rdy/ovf got %0d/%b/%b/%b expected 0/0/1/0",
                     o_occ, o_rsp_vld, o_req_rdy, o_overflow_r);
        end
        tick();
        #1;
        n_vec++;
        if ({o_occ, o_rsp_vld} !== {OW'(0), 1'b0}) begin
            n_err++;
            $display("[TB] FAIL mid_stray_ignored: occ/vld got %0d/%b expected 0/0", o_occ, o_rsp_vld);
        end
    endtask

    // Random client traffic with occasional resets, checked every cycle
    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(63) != 0);
            i_req_vld = 1'($urandom_range(1));
            i_req_prod_id = id_t'($urandom);
            i_req_level = level_t'($urandom);
            i_rsp_rdy = ($urandom_range(3) != 0);
            #1;
            n_vec++;
            if ({o_req_rdy, o_lut_vld} !== {(resv_m != DEPTH), model_acc()}) begin
                n_err++;
                $display("[TB] FAIL rnd_hs_c%0d: rdy/lut_vld got %b/%b expected %b/%b",
                         k, o_req_rdy, o_lut_vld, (resv_m != DEPTH), model_acc());
            end
            if (model_acc()) begin
                n_vec++;
                if ({o_lut_prod_id, o_lut_level} !== {i_req_prod_id, i_req_level}) begin
                    n_err++;
                    $display("[TB] FAIL rnd_issue_c%0d: got %h expected %h",
                             k, {o_lut_prod_id, o_lut_level}, {i_req_prod_id, i_req_level});
                end
            end
            n_vec++;
            if ({o_occ, o_rsp_vld, o_overflow_r} !== {OW'(exp_q.size()), (exp_q.size() != 0), ovf_m}) begin
                n_err++;
                $display("[TB] FAIL rnd_status_c%0d: occ/vld/ovf got %0d/%b/%b expected %0d/%b/%b",
                         k, o_occ, o_rsp_vld, o_overflow_r, exp_q.size(), (exp_q.size() != 0), ovf_m);
            end
            if (exp_q.size() != 0) begin
                n_vec++;
                if ({o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize} !== exp_q[0]) begin
                    n_err++;
                    $display("[TB] FAIL rnd_head_c%0d: got %h expected %h", k,
                             {o_rsp_key, o_rsp_size, o_rsp_error, o_rsp_listsize}, exp_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        i_req_vld = 1'b0;
        i_req_prod_id = '0;
        i_req_level = '0;
        i_lut_vld_r = 1'b0;
        i_lut_key = '0;
        i_lut_size = '0;
        i_lut_error = 1'b0;
        i_lut_listsize = '0;
        i_rsp_rdy = 1'b0;
        #2;
        test_reset();
        test_single(1'b0, 16'h005A, 16'd7, 8'd3);
        test_single(1'b1, 16'h00FF, 16'd9, 8'd5);
        test_backpressure();
        test_simultaneous();
        test_wrap_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
